lagd_spi_host: RTL and testbench

Single-lane SPI host controller that drives the SoC's SPI slave port and issues 32-bit memory write and read transactions into the SoC AXI space. It sits on the off-chip side: the FPGA test harness and the chip-level testbench use it to preload L2 and stack memory and the Ising core L1 memories, and to read results back. A valid/ready request/response interface feeds a divided-clock bit shifter in SPI mode 0.

---
 rtl/lagd_spi_host_pkg.sv | 26 ++
 rtl/lagd_spi_clkgen.sv | 37 +++
 rtl/lagd_spi_host.sv | 136 +++++++++++++
 tb/tb_lagd_spi_host.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/lagd_spi_host_pkg.sv
// Shared constants, FSM state type and frame builder for the SPI host.
package lagd_spi_host_pkg;

  localparam logic [7:0] SpiCmdWrite = 8'h02;
  localparam logic [7:0] SpiCmdRead  = 8'h0B;

  localparam int unsigned FrameBits = 72;  // cmd + addr + wdata
  localparam int unsigned HdrBits   = 40;  // cmd + addr
  localparam int unsigned DataBits  = 32;

  typedef enum logic [2:0] {
    IDLE, CS_SETUP, SHIFT, DUMMY, RX, CS_HOLD, RESP
  } state_e;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } spi_req_t;

  // Reads leave the low 32 bits zero so SDO idles low through dummy and RX.
  function automatic logic [FrameBits-1:0] build_frame(spi_req_t r);
    return r.we ? {SpiCmdWrite, r.addr, r.wdata} : {SpiCmdRead, r.addr, 32'h0};
  endfunction

endpackage

// File: rtl/lagd_spi_clkgen.sv
// SCK generator: half-period tick every ClkDiv cycles while enabled.
module lagd_spi_clkgen #(
  parameter int unsigned ClkDiv = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic run_i,
  output logic sck_o,
  output logic tick_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned CntW = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(ClkDiv - 1);

  logic [CntW-1:0] cnt_q;

  assign tick_o = en_i && (cnt_q == CntMax);
  assign rise_o = tick_o && run_i && !sck_o;
  assign fall_o = tick_o && sck_o;

  // With run_i low the counter keeps timing low phases but SCK never rises.
  always_ff @(posedge clk_i) begin
    if (rst_i || !en_i) begin
      cnt_q <= '0;
      sck_o <= 1'b0;
    end else if (tick_o) begin
      cnt_q <= '0;
      sck_o <= run_i && !sck_o;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/lagd_spi_host.sv
// SPI mode-0 host issuing 32-bit write/read frames from a valid/ready request port.
module lagd_spi_host
  import lagd_spi_host_pkg::*;
#(
  parameter int unsigned ClkDiv      = 4,
  parameter int unsigned DummyCycles = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        busy_o,
  output logic        spi_sck_o,
  output logic        spi_csn_o,
  output logic        spi_sdo_o,
  input  logic        spi_sdi_i
);

  localparam logic [7:0] LastFrame = 8'(FrameBits - 1);
  localparam logic [7:0] LastHdr   = 8'(HdrBits - 1);
  localparam logic [7:0] LastData  = 8'(DataBits - 1);
  localparam logic [7:0] LastDummy = 8'((DummyCycles > 0) ? DummyCycles - 1 : 0);

  state_e         state_q, state_d;
  logic [71:0]    tx_q;
  logic [31:0]    rx_q;
  logic [7:0]     bit_cnt_q, dummy_cnt_q;
  logic           we_q, csn_q, rsp_valid_q;
  logic           en, run, tick, rise, fall;
  logic           req_fire, rsp_fire;
  spi_req_t       req;

  assign req         = '{we: req_we_i, addr: req_addr_i, wdata: req_wdata_i};
  assign req_ready_o = (state_q == IDLE) && !rst_i;
  assign req_fire    = req_valid_i && req_ready_o;
  assign rsp_fire    = rsp_valid_q && rsp_ready_i;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rx_q;
  assign busy_o      = (state_q != IDLE);
  assign spi_csn_o   = csn_q;
  assign spi_sdo_o   = tx_q[71];

  lagd_spi_clkgen #(.ClkDiv(ClkDiv)) u_clkgen (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (en),
    .run_i  (run),
    .sck_o  (spi_sck_o),
    .tick_o (tick),
    .rise_o (rise),
    .fall_o (fall)
  );

  always_comb begin
    state_d = state_q;
    en      = 1'b0;
    run     = 1'b0;
    case (state_q)
      IDLE:     if (req_valid_i) state_d = CS_SETUP;
      CS_SETUP: begin
        en = 1'b1; run = 1'b1;
        if (rise) state_d = SHIFT;
      end
      SHIFT: begin
        en = 1'b1; run = 1'b1;
        if (fall && bit_cnt_q == (we_q ? LastFrame : LastHdr))
          state_d = we_q ? CS_HOLD : ((DummyCycles == 0) ? RX : DUMMY);
      end
      DUMMY: begin
        en = 1'b1; run = 1'b1;
        if (fall && dummy_cnt_q == LastDummy) state_d = RX;
      end
      RX: begin
        en = 1'b1; run = 1'b1;
        if (fall && bit_cnt_q == LastData) state_d = CS_HOLD;
      end
      // Two low half-periods: the tail of the last SCK cycle, then the hold.
      CS_HOLD: begin
        en = 1'b1;
        if (tick && bit_cnt_q[0]) state_d = RESP;
      end
      // The clkgen tick doubles as the minimum CSN-high gap timer.
      RESP: begin
        en = 1'b1;
        if ((tick || bit_cnt_q[0]) && (rsp_fire || !rsp_valid_q)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      tx_q        <= '0;
      rx_q        <= '0;
      bit_cnt_q   <= '0;
      dummy_cnt_q <= '0;
      we_q        <= 1'b0;
      csn_q       <= 1'b1;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      csn_q   <= !(state_d inside {CS_SETUP, SHIFT, DUMMY, RX, CS_HOLD});

      if (state_q == CS_HOLD && state_d == RESP) rsp_valid_q <= 1'b1;
      else if (rsp_fire)                         rsp_valid_q <= 1'b0;

      if (state_d != state_q) bit_cnt_q <= '0;
      else begin
        case (state_q)
          SHIFT, RX:     if (fall) bit_cnt_q <= bit_cnt_q + 8'd1;
          CS_HOLD, RESP: if (tick) bit_cnt_q <= 8'd1;
          default: ;
        endcase
      end

      if (req_fire) begin
        tx_q        <= build_frame(req);
        rx_q        <= '0;
        we_q        <= req_we_i;
        dummy_cnt_q <= '0;
      end else begin
        if (fall && (state_q inside {SHIFT, DUMMY, RX})) tx_q <= {tx_q[70:0], 1'b0};
        if (rise && state_q == RX) rx_q <= {rx_q[30:0], spi_sdi_i};
        if (fall && state_q == DUMMY) dummy_cnt_q <= dummy_cnt_q + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_lagd_spi_host.sv
// Directed bench: two host configurations (ClkDiv 4 / 32 dummy, ClkDiv 1 / no dummy) and a mode-0 slave model.
module tb_lagd_spi_host;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, sel, req_valid, req_we, rsp_ready;
  logic        sdi = 1'b0;
  logic [31:0] req_addr, req_wdata, sdata;

  logic        r0_ready, r0_rspv, r0_busy, r0_sck, r0_csn, r0_sdo;
  logic        r1_ready, r1_rspv, r1_busy, r1_sck, r1_csn, r1_sdo;
  logic [31:0] r0_rdata, r1_rdata;

  lagd_spi_host #(.ClkDiv(4), .DummyCycles(32)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid && !sel), .req_ready_o(r0_ready),
    .req_we_i(req_we), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(r0_rspv), .rsp_ready_i(rsp_ready), .rsp_rdata_o(r0_rdata), .busy_o(r0_busy),
    .spi_sck_o(r0_sck), .spi_csn_o(r0_csn), .spi_sdo_o(r0_sdo), .spi_sdi_i(sdi));

  lagd_spi_host #(.ClkDiv(1), .DummyCycles(0)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid && sel), .req_ready_o(r1_ready),
    .req_we_i(req_we), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(r1_rspv), .rsp_ready_i(rsp_ready), .rsp_rdata_o(r1_rdata), .busy_o(r1_busy),
    .spi_sck_o(r1_sck), .spi_csn_o(r1_csn), .spi_sdo_o(r1_sdo), .spi_sdi_i(sdi));

  wire        req_ready = sel ? r1_ready : r0_ready;
  wire        rsp_valid = sel ? r1_rspv  : r0_rspv;
  wire        busy      = sel ? r1_busy  : r0_busy;
  wire        sck       = sel ? r1_sck   : r0_sck;
  wire        csn       = sel ? r1_csn   : r0_csn;
  wire        sdo       = sel ? r1_sdo   : r0_sdo;
  wire [31:0] rdata     = sel ? r1_rdata : r0_rdata;

  // Monitor: cycle numbers relative to the accepting edge, SCK rise sampling, CSN gap.
  int cyc = 0, acc_e = 0, acc_prev = 0, acc_cnt = 0, rsp_rel = -1, rises = 0;
  int hi_run = 0, last_gap = 0;
  logic sck_prev = 1'b0;
  logic [127:0] sh = '0;

  always @(posedge clk) begin
    if (req_valid && req_ready) begin
      acc_prev = acc_e; acc_e = cyc; acc_cnt++; rsp_rel = -1; rises = 0; sh = '0;
    end else if (sck && !sck_prev) begin
      rises++; sh = {sh[126:0], sdo};
    end
    if (rsp_valid && rsp_rel < 0) rsp_rel = cyc - acc_e;
    if (csn) hi_run++;
    else begin
      if (hi_run > 0) last_gap = hi_run;
      hi_run = 0;
    end
    sck_prev = sck;
    cyc++;
  end

  // Slave: presents read data bit while SCK is low, ahead of the RX rising edge.
  always @(negedge clk) begin : slave
    int idx;
    if (!sck) begin
      idx = rises - 40 - (sel ? 0 : 32);
      sdi = (idx >= 0 && idx < 32) ? sdata[31 - idx] : 1'b0;
    end
  end

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] d, output bit ok);
    int n0;
    n0 = acc_cnt;
    ok = 1'b0;
    @(negedge clk);
    req_we = we; req_addr = a; req_wdata = d; req_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (acc_cnt != n0) begin ok = 1'b1; break; end
    end
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (rsp_valid) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      if (!busy) break;
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic        sel;
    logic        we;
    logic [31:0] addr, wdata, sdata, exp_rdata;
    int          exp_cyc, exp_rises;
  } vec_t;

  vec_t vecs[5];

  task automatic run_vec(input vec_t v, input string tag);
    bit ok;
    logic [31:0] rd;
    logic [71:0] f;
    sel = v.sel; sdata = v.sdata; rsp_ready = 1'b1;
    issue(v.we, v.addr, v.wdata, ok);
    chk({tag, "_accept"}, 128'(ok), 128'd1);
    wait_rsp(ok);
    chk({tag, "_rsp_seen"}, 128'(ok), 128'd1);
    rd = rdata;
    @(posedge clk); #1;
    f = {v.we ? 8'h02 : 8'h0B, v.addr, v.we ? v.wdata : 32'h0};
    chk({tag, "_rdata"}, 128'(rd), 128'(v.exp_rdata));
    chk({tag, "_rsp_cycle"}, 128'(rsp_rel), 128'(v.exp_cyc));
    chk({tag, "_sck_rises"}, 128'(rises), 128'(v.exp_rises));
    chk({tag, "_frame_bits"}, sh, {56'b0, f} << (v.exp_rises - 72));
    @(negedge clk);
    wait_idle();
  endtask

  initial begin
    bit ok;
    int bad;
    vecs[0] = '{1'b0, 1'b1, 32'h1000_0000, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 32'h0,         585, 72};
    vecs[1] = '{1'b0, 1'b0, 32'h1400_0010, 32'h5555_5555, 32'hCAFE_F00D, 32'hCAFE_F00D, 841, 104};
    vecs[2] = '{1'b1, 1'b0, 32'h1C00_0004, 32'h0,         32'h1234_5678, 32'h1234_5678, 147, 72};
    vecs[3] = '{1'b1, 1'b1, 32'h0000_0FFC, 32'h8000_0001, 32'hFFFF_FFFF, 32'h0,         147, 72};
    vecs[4] = '{1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0,         32'hA5A5_5A5A, 32'hA5A5_5A5A, 841, 104};

    rst = 1'b1; sel = 1'b0; req_valid = 1'b0; req_we = 1'b0; rsp_ready = 1'b1;
    req_addr = '0; req_wdata = '0; sdata = '0;
    repeat (3) @(negedge clk);
    chk("reset_req_ready", 128'(req_ready), 128'd0);
    chk("reset_outputs", 128'({rsp_valid, rdata, busy, sck, csn, sdo}), 128'({1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0}));
    rst = 1'b0;
    @(negedge clk);
    chk("idle_req_ready", 128'(req_ready), 128'd1);

    for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Response back-pressure: everything frozen while rsp_ready is low.
    sel = 1'b0; sdata = 32'h0BAD_C0DE; rsp_ready = 1'b0;
    issue(1'b0, 32'h1400_0020, 32'h0, ok);
    wait_rsp(ok);
    chk("hold_rsp_seen", 128'(ok), 128'd1);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if ({rsp_valid, rdata, req_ready, csn, sck} !== {1'b1, 32'h0BAD_C0DE, 1'b0, 1'b1, 1'b0}) bad++;
      @(negedge clk);
    end
    chk("hold_stable_cycles_bad", 128'(bad), 128'd0);
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("hold_rsp_drop", 128'(rsp_valid), 128'd0);
    wait_idle();

    // Back-to-back writes with req_valid held high.
    sel = 1'b0; rsp_ready = 1'b1;
    begin
      int n0;
      n0 = acc_cnt;
      req_we = 1'b1; req_addr = 32'h1000_0100; req_wdata = 32'h1111_2222; req_valid = 1'b1;
      for (int i = 0; i < 50 && acc_cnt == n0; i++) @(negedge clk);
      req_addr = 32'h1000_0104; req_wdata = 32'h3333_4444;
      for (int i = 0; i < 1000 && acc_cnt < n0 + 2; i++) @(negedge clk);
      req_valid = 1'b0;
      chk("b2b_two_accepts", 128'(acc_cnt - n0), 128'd2);
    end
    chk("b2b_period", 128'(acc_e - acc_prev), 128'd589);
    wait_rsp(ok);
    @(posedge clk); #1;
    chk("b2b_gap_ge_clkdiv", 128'(last_gap >= 4), 128'd1);
    chk("b2b_rsp_cycle", 128'(rsp_rel), 128'd585);
    chk("b2b_frame_bits", sh, {56'b0, 8'h02, 32'h1000_0104, 32'h3333_4444});
    @(negedge clk);
    wait_idle();

    // Reset in the middle of a read: frame dropped, no response.
    sel = 1'b0; sdata = 32'hCAFE_F00D;
    issue(1'b0, 32'h1400_0010, 32'h0, ok);
    for (int i = 0; i < 2000 && rises < 40; i++) @(negedge clk);
    chk("midreset_reached_40", 128'(rises), 128'd40);
    rst = 1'b1;
    @(negedge clk);
    chk("midreset_outputs", 128'({csn, sck, sdo, busy, rsp_valid, req_ready}), 128'(6'b100000));
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 900; i++) begin
      if (rsp_valid) bad++;
      @(negedge clk);
    end
    chk("midreset_no_rsp", 128'(bad), 128'd0);
    run_vec(vecs[0], "post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
